// File: rtl/wm8978_i2c_sched.sv
// Write scheduler for the WM8978 codec. Arbitrates boot-table writes (priority) and
// queued runtime writes onto the shared I2C driver, with retry and inter-transaction gap.
`timescale 1ns/1ps
module wm8978_i2c_sched #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        boot_exec,
    input  logic [15:0] boot_data,
    output logic        boot_done,
    input  logic        cfg_done,
    input  logic        rt_valid,
    input  logic [15:0] rt_data,
    output logic        rt_ready,
    output logic        i2c_exec,
    output logic [7:0]  i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_addr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t         state_q;
    logic           src_boot_q;
    logic           retry_pend_q;
    logic [RW-1:0]  retry_q;
    logic [TW-1:0]  tmo_q;
    logic [GW-1:0]  gap_q;
    logic           boot_pend_q;
    logic [15:0]    boot_word_q;
    logic           exec_q;
    logic           done_q;
    logic           err_q;
    logic [7:0]     err_addr_q;
    logic [7:0]     addr_q;
    logic [7:0]     data_q;

    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic xfer_ok;
    logic xfer_fail;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = rt_valid & ~fifo_full;
    assign pop        = (state_q == S_IDLE) & ~boot_pend_q & cfg_done & ~fifo_empty;

    // A done pulse outranks a coincident timeout expiry.
    assign xfer_ok    = i2c_done & ~i2c_ack;
    assign xfer_fail  = i2c_done ? i2c_ack : (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rt_data;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            src_boot_q   <= 1'b0;
            retry_pend_q <= 1'b0;
            retry_q      <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            boot_pend_q  <= 1'b0;
            boot_word_q  <= '0;
            exec_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            exec_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (boot_pend_q) begin
                        addr_q     <= boot_word_q[15:8];
                        data_q     <= boot_word_q[7:0];
                        src_boot_q <= 1'b1;
                        retry_q    <= '0;
                        exec_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end else if (pop) begin
                        addr_q     <= mem_q[rd_ptr_q][15:8];
                        data_q     <= mem_q[rd_ptr_q][7:0];
                        src_boot_q <= 1'b0;
                        retry_q    <= '0;
                        exec_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (xfer_ok) begin
                        retry_pend_q <= 1'b0;
                        gap_q        <= '0;
                        state_q      <= S_GAP;
                    end else if (xfer_fail) begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                        if (retry_q == RW'(MAX_RETRY)) begin
                            retry_pend_q <= 1'b0;
                            err_q        <= 1'b1;
                            err_addr_q   <= addr_q;
                        end else begin
                            retry_q      <= retry_q + RW'(1);
                            retry_pend_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        if (retry_pend_q) begin
                            retry_pend_q <= 1'b0;
                            exec_q       <= 1'b1;
                            state_q      <= S_ISSUE;
                        end else begin
                            if (src_boot_q) begin
                                done_q      <= 1'b1;
                                boot_pend_q <= 1'b0;
                            end
                            state_q <= S_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Placed after the FSM so a new request wins over a same-cycle clear.
            if (boot_exec) begin
                boot_pend_q <= 1'b1;
                boot_word_q <= boot_data;
            end
        end
    end

    assign boot_done  = done_q;
    assign rt_ready   = ~fifo_full;
    assign i2c_exec   = exec_q;
    assign i2c_addr   = addr_q;
    assign i2c_data_w = data_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_wm8978_i2c_sched.sv
// Bench for wm8978_i2c_sched: timestamp-based reference model checked every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_wm8978_i2c_sched;

    localparam int unsigned FD = 4;
    localparam int unsigned MR = 3;
    localparam int unsigned GC = 16;
    localparam int unsigned TC = 4096;

    logic        clk = 1'b0;
    logic        sys_rst, boot_exec, cfg_done, rt_valid, i2c_done, i2c_ack;
    logic [15:0] boot_data, rt_data;
    logic        boot_done, rt_ready, i2c_exec, busy, err;
    logic [7:0]  i2c_addr, i2c_data_w, err_addr;

    wm8978_i2c_sched #(
        .FIFO_DEPTH (FD),
        .MAX_RETRY  (MR),
        .GAP_CYC    (GC),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .boot_exec (boot_exec),
        .boot_data (boot_data),
        .boot_done (boot_done),
        .cfg_done  (cfg_done),
        .rt_valid  (rt_valid),
        .rt_data   (rt_data),
        .rt_ready  (rt_ready),
        .i2c_exec  (i2c_exec),
        .i2c_addr  (i2c_addr),
        .i2c_data_w(i2c_data_w),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .err       (err),
        .err_addr  (err_addr)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Driver stand-in: mode 0 fixed latency (NACK on one address), 1 silent, 2 random.
    int         drv_mode = 0;
    int         drv_lat  = 10;
    int         drv_cnt  = 0;
    bit         drv_nack = 0;
    bit         nack_en  = 0;
    logic [7:0] nack_addr = 8'h00;

    initial begin
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
            if (sys_rst) begin
                drv_cnt = 0;
            end else begin
                if (drv_cnt > 0) begin
                    drv_cnt--;
                    if (drv_cnt == 0) begin
                        i2c_done = 1'b1;
                        i2c_ack  = drv_nack;
                    end
                end else if (drv_mode == 2 && $urandom_range(63) == 0) begin
                    i2c_done = 1'b1;
                    i2c_ack  = 1'($urandom_range(1));
                end
                if (i2c_exec && drv_mode != 1) begin
                    if (drv_mode == 2) begin
                        drv_cnt  = $urandom_range(40, 1);
                        drv_nack = ($urandom_range(3) == 0);
                    end else begin
                        drv_cnt  = drv_lat;
                        drv_nack = nack_en && (i2c_addr == nack_addr);
                    end
                end
            end
        end
    end

    // Reference model: one outstanding write described by timestamps.
    logic [15:0] mq[$];
    bit          m_act, m_boot, m_retry, m_bp, m_bd, m_err;
    logic [15:0] m_word, m_bw;
    logic [7:0]  m_eaddr;
    int          m_att, m_exec_t, m_resp_t;

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_boot = 0; m_retry = 0; m_bp = 0; m_bd = 0; m_err = 0;
        m_word = '0; m_bw = '0; m_eaddr = '0;
        m_att = 0; m_exec_t = -1; m_resp_t = -1;
    endtask

    task automatic model_start(input logic [15:0] w, input bit from_boot, input int t);
        m_act = 1; m_word = w; m_boot = from_boot;
        m_att = 1; m_exec_t = t + 1; m_resp_t = -1;
    endtask

    task automatic model_step(input int t);
        bit push_ok, nbd, resp, fail;
        push_ok = rt_valid && (mq.size() < FD);
        nbd = 0;
        if (m_act) begin
            if (m_resp_t < 0) begin
                if (t > m_exec_t) begin
                    resp = 0; fail = 0;
                    if (i2c_done) begin
                        resp = 1; fail = i2c_ack;
                    end else if (t - m_exec_t == int'(TC)) begin
                        resp = 1; fail = 1;
                    end
                    if (resp) begin
                        m_resp_t = t;
                        m_retry  = fail && (m_att <= int'(MR));
                        if (fail && !m_retry) begin
                            m_err = 1; m_eaddr = m_word[15:8];
                        end
                    end
                end
            end else if (t == m_resp_t + int'(GC)) begin
                if (m_retry) begin
                    m_att++; m_exec_t = t + 1; m_resp_t = -1;
                end else begin
                    m_act = 0;
                    if (m_boot) begin
                        nbd = 1; m_bp = 0;
                    end
                end
            end
        end else if (m_bp) begin
            model_start(m_bw, 1, t);
        end else if (cfg_done && mq.size() > 0) begin
            model_start(mq.pop_front(), 0, t);
        end
        if (push_ok) mq.push_back(rt_data);
        if (boot_exec) begin
            m_bp = 1; m_bw = boot_data;
        end
        m_bd = nbd;
    endtask

    int         ex_cyc[$];
    logic [7:0] ex_adr[$];
    logic [7:0] ex_dat[$];
    int         done_last = -1;
    int         bd_cyc = -1;
    int         bd_cnt = 0;

    always @(negedge clk) begin
        logic [63:0] got, exp;
        bit m_exec;
        if (sys_rst) begin
            model_reset();
        end else begin
            m_exec = m_act && (m_resp_t < 0) && (cyc == m_exec_t);
            exp = {35'd0, m_exec, m_act, 1'(mq.size() < FD), m_bd, m_err, m_eaddr,
                   (m_act ? m_word : 16'h0000)};
            got = {35'd0, i2c_exec, busy, rt_ready, boot_done, err, err_addr,
                   (m_act ? {i2c_addr, i2c_data_w} : 16'h0000)};
            check("cycle outputs", got, exp);
            if (i2c_exec) begin
                ex_cyc.push_back(cyc); ex_adr.push_back(i2c_addr); ex_dat.push_back(i2c_data_w);
            end
            if (i2c_done) done_last = cyc;
            if (boot_done) begin
                bd_cyc = cyc; bd_cnt++;
            end
            model_step(cyc);
        end
    end

    task automatic push_rt(input logic [15:0] w);
        rt_valid = 1'b1; rt_data = w;
        tick(1);
        rt_valid = 1'b0;
    endtask

    task automatic wait_exec(input int n0, input int budget);
        int k = 0;
        while (ex_cyc.size() <= n0 && k < budget) begin tick(1); k++; end
        check("exec wait bound", 1'(k < budget), 1'b1);
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        int idle = 0;
        while (idle < 3 && k < budget) begin
            tick(1); k++;
            idle = busy ? 0 : idle + 1;
        end
        check("quiet wait bound", 1'(k < budget), 1'b1);
    endtask

    initial begin
        int n0, c0, b0, k;
        bit boot_out;
        sys_rst = 1'b1; boot_exec = 1'b0; boot_data = '0; cfg_done = 1'b0;
        rt_valid = 1'b0; rt_data = '0;
        tick(3);
        check("reset exec", i2c_exec, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset rt_ready", rt_ready, 1'b1);
        check("reset err", {boot_done, err, err_addr}, 10'h000);
        sys_rst = 1'b0;
        tick(3);

        // Boot write with 200-cycle ACK
        drv_mode = 0; drv_lat = 200; nack_en = 0;
        n0 = ex_cyc.size(); b0 = bd_cnt; c0 = cyc;
        boot_exec = 1'b1; boot_data = 16'h0A5C;
        tick(1);
        boot_exec = 1'b0;
        wait_exec(n0, 20);
        k = 0;
        while (bd_cnt == b0 && k < 1000) begin tick(1); k++; end
        check("boot_done bound", 1'(k < 1000), 1'b1);
        check("boot exec latency", ex_cyc[n0] - c0, 2);
        check("boot addr/data", {ex_adr[n0], ex_dat[n0]}, 16'h0A5C);
        check("boot ack latency", done_last - ex_cyc[n0], 200);
        check("boot_done after done", bd_cyc - done_last, GC + 1);
        check("boot exec count", ex_cyc.size() - n0, 1);

        // Runtime FIFO fills while cfg_done low, drains in order
        drv_lat = 5;
        n0 = ex_cyc.size();
        push_rt(16'h10A1); push_rt(16'h20B2); push_rt(16'h30C3); push_rt(16'h40D4);
        check("rt_ready full", rt_ready, 1'b0);
        push_rt(16'h50E5);
        tick(30);
        check("no exec while cfg low", ex_cyc.size() - n0, 0);
        c0 = cyc;
        cfg_done = 1'b1;
        wait_quiet(500);
        check("drain count", ex_cyc.size() - n0, 4);
        check("first drain exec", ex_cyc[n0] - c0, 1);
        for (int i = 0; i < 4; i++) begin
            check("drain order", {ex_adr[n0 + i], ex_dat[n0 + i]},
                  {4'(i + 1), 4'h0, 4'(10 + i), 4'(i + 1)});
        end
        for (int i = 1; i < 4; i++) begin
            check("drain spacing", ex_cyc[n0 + i] - ex_cyc[n0 + i - 1], 5 + GC + 2);
        end

        // Silent driver: timeouts, four attempts, then drop
        drv_mode = 1;
        n0 = ex_cyc.size();
        push_rt(16'h0511);
        wait_quiet(20000);
        check("timeout attempts", ex_cyc.size() - n0, 4);
        check("timeout spacing", ex_cyc[n0 + 1] - ex_cyc[n0], TC + GC + 1);
        check("timeout err", {err, err_addr}, 9'h105);

        // NACK on address 0x03; the next queued word still goes out
        drv_mode = 0; drv_lat = 8; nack_en = 1; nack_addr = 8'h03;
        n0 = ex_cyc.size();
        push_rt(16'h03AA); push_rt(16'h04BB);
        wait_quiet(2000);
        check("nack exec count", ex_cyc.size() - n0, 5);
        for (int i = 0; i < 4; i++) check("nack retry addr", ex_adr[n0 + i], 8'h03);
        check("after-drop addr", ex_adr[n0 + 4], 8'h04);
        check("nack err", {err, err_addr}, 9'h103);
        nack_en = 0;

        // Boot and runtime requests arrive while a runtime write is in flight
        drv_lat = 50;
        n0 = ex_cyc.size(); b0 = bd_cnt;
        push_rt(16'h0601);
        wait_exec(n0, 20);
        tick(5);
        boot_exec = 1'b1; boot_data = 16'h0702;
        rt_valid = 1'b1; rt_data = 16'h0803;
        tick(1);
        boot_exec = 1'b0; rt_valid = 1'b0;
        wait_quiet(1000);
        check("priority exec count", ex_cyc.size() - n0, 3);
        check("priority order", {ex_adr[n0], ex_adr[n0 + 1], ex_adr[n0 + 2]}, 24'h060708);
        check("priority boot_done", bd_cnt - b0, 1);

        // Reset in the middle of WAIT
        drv_lat = 100;
        n0 = ex_cyc.size();
        push_rt(16'h0904);
        wait_exec(n0, 20);
        tick(10);
        sys_rst = 1'b1;
        #1;
        check("rst exec", i2c_exec, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 1'b0);
        check("rst rt_ready", rt_ready, 1'b1);
        tick(2);
        sys_rst = 1'b0;
        n0 = ex_cyc.size();
        tick(100);
        check("no exec after reset", ex_cyc.size() - n0, 0);

        // Randomized traffic
        drv_mode = 2; boot_out = 0;
        for (int i = 0; i < 3000; i++) begin
            rt_valid = ($urandom_range(2) == 0);
            rt_data  = 16'($urandom);
            if ($urandom_range(199) == 0) cfg_done = ~cfg_done;
            boot_exec = 1'b0;
            if (boot_done) boot_out = 0;
            if (!boot_out && $urandom_range(39) == 0) begin
                boot_exec = 1'b1; boot_data = 16'($urandom); boot_out = 1;
            end
            tick(1);
        end
        rt_valid = 1'b0; boot_exec = 1'b0; cfg_done = 1'b1;
        drv_mode = 0; drv_lat = 5;
        wait_quiet(20000);
        check("final fifo drained", rt_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
